// File: rtl/rbm_vote_classifier.sv
// Per-class spike vote accumulator with sequential argmax over NUM_CLASSES counters.
// Latency: count visible the cycle after its sample; done NUM_CLASSES+1 cycles after the last sample.
// Backpressure: none; out-of-order or unexpected spike_valid is dropped and flagged on sticky err.
module rbm_vote_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int CNT_W       = 8,
    parameter int ITER_W      = 8,
    parameter int CLS_W       = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iter,
    input  logic              spike_valid,
    input  logic              spike,
    input  logic [CLS_W-1:0]  spike_class,
    output logic              busy,
    output logic              done,
    output logic [CLS_W-1:0]  winner,
    output logic [CNT_W-1:0]  winner_count,
    output logic              tie,
    output logic              err,
    input  logic [CLS_W-1:0]  rd_class,
    output logic [CNT_W-1:0]  rd_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt [NUM_CLASSES];
    logic [ITER_W-1:0] iter_cnt;
    logic [ITER_W-1:0] num_iter_q;
    logic [CLS_W-1:0]  exp_cls;
    logic [CLS_W-1:0]  scan_idx;
    logic [CNT_W-1:0]  max_val;
    logic [CLS_W-1:0]  max_idx;
    logic              tie_run;
    logic [CLS_W-1:0]  winner_q;
    logic [CNT_W-1:0]  winner_count_q;
    logic              tie_q;
    logic              err_q;

    logic              start_acc;
    logic              accept;
    logic              last_cls;
    logic [ITER_W-1:0] iter_nxt;
    logic [CNT_W-1:0]  scan_val;
    logic [CNT_W-1:0]  cand_val;
    logic [CLS_W-1:0]  cand_idx;
    logic              cand_tie;
    logic [CNT_W-1:0]  rd_count_c;

    assign start_acc = (state_q == IDLE) && start;
    assign accept    = (state_q == ACCUM) && spike_valid && (spike_class == exp_cls);
    assign last_cls  = (exp_cls == LAST_CLS);
    assign iter_nxt  = iter_cnt + ITER_W'(1);

    always_comb begin
        scan_val   = '0;
        rd_count_c = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (scan_idx == CLS_W'(i)) scan_val = cnt[i];
            if (rd_class == CLS_W'(i)) rd_count_c = cnt[i];
        end
    end

    // Strict greater-than keeps the lowest index on equal counts.
    always_comb begin
        cand_val = max_val;
        cand_idx = max_idx;
        cand_tie = tie_run;
        if (scan_idx == '0) begin
            cand_val = scan_val;
            cand_idx = scan_idx;
            cand_tie = 1'b0;
        end else if (scan_val > max_val) begin
            cand_val = scan_val;
            cand_idx = scan_idx;
            cand_tie = 1'b0;
        end else if (scan_val == max_val) begin
            cand_tie = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = (num_iter == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                if (accept && last_cls && (iter_nxt == num_iter_q)) state_d = SCAN;
            end
            SCAN: begin
                if (scan_idx == LAST_CLS) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            iter_cnt       <= '0;
            num_iter_q     <= '0;
            exp_cls        <= '0;
            scan_idx       <= '0;
            max_val        <= '0;
            max_idx        <= '0;
            tie_run        <= 1'b0;
            winner_q       <= '0;
            winner_count_q <= '0;
            tie_q          <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            if (start_acc) begin
                for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
                iter_cnt       <= '0;
                num_iter_q     <= num_iter;
                exp_cls        <= '0;
                scan_idx       <= '0;
                winner_q       <= '0;
                winner_count_q <= '0;
                tie_q          <= (num_iter == '0);
                err_q          <= 1'b0;
            end else if (spike_valid && !accept) begin
                err_q <= 1'b1;
            end

            if (accept) begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    if ((exp_cls == CLS_W'(i)) && (cnt[i] != CNT_MAX)) begin
                        cnt[i] <= cnt[i] + CNT_W'(spike);
                    end
                end
                if (last_cls) begin
                    exp_cls  <= '0;
                    iter_cnt <= iter_nxt;
                end else begin
                    exp_cls <= exp_cls + CLS_W'(1);
                end
            end

            if (state_q == SCAN) begin
                max_val <= cand_val;
                max_idx <= cand_idx;
                tie_run <= cand_tie;
                if (scan_idx == LAST_CLS) begin
                    scan_idx       <= '0;
                    winner_q       <= cand_idx;
                    winner_count_q <= cand_val;
                    tie_q          <= cand_tie;
                end else begin
                    scan_idx <= scan_idx + CLS_W'(1);
                end
            end
        end
    end

    assign busy         = (state_q == ACCUM) || (state_q == SCAN);
    assign done         = (state_q == DONE);
    assign winner       = winner_q;
    assign winner_count = winner_count_q;
    assign tie          = tie_q;
    assign err          = err_q;
    assign rd_count     = rd_count_c;

endmodule

// File: tb/tb_rbm_vote_classifier.sv
// Scoreboard bench: directed runs push expected results; monitors pop and compare on done.
module tb_rbm_vote_classifier;

    logic clock;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        logic [3:0] w;
        logic [7:0] c;
        logic       t;
        logic       e;
        int         due;
    } exp_t;

    exp_t m_q[$];
    exp_t s_q[$];

    // main instance, default parameters
    logic       m_start, m_sv, m_sp;
    logic [7:0] m_num;
    logic [3:0] m_sc, m_rd, m_win;
    logic       m_busy, m_done, m_tie, m_err;
    logic [7:0] m_wc, m_rdc;

    // saturation instance, 2-bit counters
    logic       s_start, s_sv, s_sp;
    logic [7:0] s_num;
    logic [3:0] s_sc, s_rd, s_win;
    logic       s_busy, s_done, s_tie, s_err;
    logic [1:0] s_wc, s_rdc;

    rbm_vote_classifier u_dut (
        .clock(clock), .reset(reset), .start(m_start), .num_iter(m_num),
        .spike_valid(m_sv), .spike(m_sp), .spike_class(m_sc),
        .busy(m_busy), .done(m_done), .winner(m_win), .winner_count(m_wc),
        .tie(m_tie), .err(m_err), .rd_class(m_rd), .rd_count(m_rdc)
    );

    rbm_vote_classifier #(.CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .start(s_start), .num_iter(s_num),
        .spike_valid(s_sv), .spike(s_sp), .spike_class(s_sc),
        .busy(s_busy), .done(s_done), .winner(s_win), .winner_count(s_wc),
        .tie(s_tie), .err(s_err), .rd_class(s_rd), .rd_count(s_rdc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input bit s, input logic [3:0] w, input logic [7:0] c,
                            input logic t, input logic e, input int lat);
        exp_t x;
        x.w = w; x.c = c; x.t = t; x.e = e; x.due = cyc + lat;
        if (s) s_q.push_back(x);
        else   m_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input bit s, input logic [3:0] c, input logic b);
        if (s) begin s_sv = 1'b1; s_sc = c; s_sp = b; end
        else   begin m_sv = 1'b1; m_sc = c; m_sp = b; end
        tick();
        m_sv = 1'b0; m_sp = 1'b0; s_sv = 1'b0; s_sp = 1'b0;
    endtask

    task automatic do_start(input bit s, input logic [7:0] n);
        if (s) begin s_start = 1'b1; s_num = n; end
        else   begin m_start = 1'b1; m_num = n; end
        tick();
        m_start = 1'b0; s_start = 1'b0;
    endtask

    task automatic run_iter(input bit s, input logic [9:0] bits);
        for (int i = 0; i < 10; i++) send(s, 4'(i), bits[i]);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((m_q.size() != 0 || s_q.size() != 0) && k < 60) begin
            tick();
            k++;
        end
        chk({name, "_drain_pending"}, m_q.size() + s_q.size(), 0);
        tick();
    endtask

    always @(posedge clock) begin
        exp_t x;
        #1;
        if (m_done) begin
            if (m_q.size() == 0) begin
                chk("main_unexpected_done", 1, 0);
            end else begin
                x = m_q.pop_front();
                chk("main_done_cycle", cyc, x.due);
                chk("main_winner", m_win, x.w);
                chk("main_winner_count", m_wc, x.c);
                chk("main_tie", m_tie, x.t);
                chk("main_err", m_err, x.e);
                chk("main_busy_at_done", m_busy, 0);
            end
        end
    end

    always @(posedge clock) begin
        exp_t x;
        #1;
        if (s_done) begin
            if (s_q.size() == 0) begin
                chk("sat_unexpected_done", 1, 0);
            end else begin
                x = s_q.pop_front();
                chk("sat_done_cycle", cyc, x.due);
                chk("sat_winner", s_win, x.w);
                chk("sat_winner_count", 32'(s_wc), x.c);
                chk("sat_tie", s_tie, x.t);
                chk("sat_err", s_err, x.e);
            end
        end
    end

    initial begin
        cyc = 0; n_tests = 0; n_fail = 0;
        reset = 1'b1;
        m_start = 0; m_sv = 0; m_sp = 0; m_num = 0; m_sc = 0; m_rd = 0;
        s_start = 0; s_sv = 0; s_sp = 0; s_num = 0; s_sc = 0; s_rd = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_winner", m_win, 0);
        chk("rst_winner_count", m_wc, 0);
        chk("rst_tie", m_tie, 0);
        chk("rst_err", m_err, 0);
        m_rd = 4'd0; #1; chk("rst_rd0", m_rdc, 0);

        // single iteration, class 2 spikes
        do_start(0, 8'd1);
        chk("single_busy", m_busy, 1);
        push_exp(0, 4'd2, 8'd1, 1'b0, 1'b0, 9 + 11);
        run_iter(0, 10'b00_0000_0100);
        m_rd = 4'd2; #1; chk("single_rd2_live", m_rdc, 1);
        wait_drain("single");

        // tie between 3 and 7 over three iterations
        do_start(0, 8'd3);
        run_iter(0, 10'b00_1000_1000);
        run_iter(0, 10'b00_1000_1000);
        push_exp(0, 4'd3, 8'd3, 1'b1, 1'b0, 9 + 11);
        run_iter(0, 10'b00_1000_1000);
        wait_drain("tie");
        m_rd = 4'd7;  #1; chk("tie_rd7", m_rdc, 3);
        m_rd = 4'd12; #1; chk("tie_rd_oob", m_rdc, 0);

        // equal 1 and 2, then 5 strictly greater clears tie
        do_start(0, 8'd2);
        run_iter(0, 10'b00_0010_0110);
        push_exp(0, 4'd5, 8'd2, 1'b0, 1'b0, 9 + 11);
        run_iter(0, 10'b00_0010_0000);
        wait_drain("tie_clear");

        // saturation on the 2-bit instance
        do_start(1, 8'd5);
        for (int it = 0; it < 4; it++) run_iter(1, 10'b00_0001_0000);
        push_exp(1, 4'd4, 8'd3, 1'b0, 1'b0, 9 + 11);
        run_iter(1, 10'b00_0001_0000);
        wait_drain("sat");
        s_rd = 4'd4; #1; chk("sat_rd4", 32'(s_rdc), 3);

        // protocol error: class 5 where 4 expected
        do_start(0, 8'd1);
        push_exp(0, 4'd6, 8'd1, 1'b0, 1'b1, 10 + 11);
        for (int i = 0; i < 4; i++) send(0, 4'(i), 1'b0);
        send(0, 4'd5, 1'b1);
        chk("proto_err_sticky", m_err, 1);
        send(0, 4'd4, 1'b0);
        send(0, 4'd5, 1'b0);
        send(0, 4'd6, 1'b1);
        for (int i = 7; i < 10; i++) send(0, 4'(i), 1'b0);
        wait_drain("proto");
        m_rd = 4'd5; #1; chk("proto_rd5_discarded", m_rdc, 0);

        // num_iter = 0 goes straight to done and clears err
        push_exp(0, 4'd0, 8'd0, 1'b1, 1'b0, 1);
        do_start(0, 8'd0);
        wait_drain("zero_iter");

        // spike in IDLE sets err; next start clears it
        send(0, 4'd0, 1'b1);
        chk("idle_spike_err", m_err, 1);
        do_start(0, 8'd1);
        chk("start_clears_err", m_err, 0);

        // start while busy is ignored
        push_exp(0, 4'd9, 8'd1, 1'b0, 1'b0, 10 + 11);
        for (int i = 0; i < 5; i++) send(0, 4'(i), 1'b0);
        do_start(0, 8'd5);
        chk("busy_start_no_err", m_err, 0);
        for (int i = 5; i < 10; i++) send(0, 4'(i), (i == 9));
        wait_drain("busy_start");

        // reset during SCAN cycle 4
        do_start(0, 8'd1);
        run_iter(0, 10'b11_1111_1111);
        repeat (3) tick();
        chk("scan_busy_before_rst", m_busy, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", m_busy, 0);
        chk("rst_mid_winner", m_win, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            m_rd = 4'(i); #1;
            chk("rst_mid_rd", m_rdc, 0);
        end
        repeat (15) tick();

        // clean run after reset
        do_start(0, 8'd1);
        push_exp(0, 4'd3, 8'd1, 1'b0, 1'b0, 9 + 11);
        run_iter(0, 10'b00_0000_1000);
        wait_drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
